// File: rtl/vc_link_buffer.sv
// -----------------------------------------------------------------------------
// vc_link_buffer
//   Inter-router link buffer with NUM_VC virtual channels, each backed by its
//   own DEPTH-flit FIFO. A round-robin arbiter with wormhole locking shares one
//   output between the VCs, so flits of different packets never interleave.
//
// Ports
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-low reset
//   in_valid      upstream flit present
//   in_vc         VC of the incoming flit
//   in_last       incoming flit is a packet tail
//   in_data       incoming flit payload
//   in_ready      per-VC space available (all zeros while in reset)
//   out_valid     flit presented downstream
//   out_vc        VC of the presented flit
//   out_last      presented flit is a tail
//   out_data      presented payload
//   out_ready     downstream accepts the presented flit
//   out_vc_ready  per-VC downstream space, used as arbitration eligibility
//
// Optional feature (macro VC_LINK_OCCUPANCY_EN)
//   vc_occupancy     registered per-VC occupancy, count[v] at slice v
//   vc_overflow_err  sticky flag for a write attempt to a full/invalid VC
// -----------------------------------------------------------------------------
module vc_link_buffer #(
  parameter int n      = 32,
  parameter int NUM_VC = 4,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [$clog2(NUM_VC)-1:0]   in_vc,
  input  logic                        in_last,
  input  logic [n-1:0]                in_data,
  output logic [NUM_VC-1:0]           in_ready,
  output logic                        out_valid,
  output logic [$clog2(NUM_VC)-1:0]   out_vc,
  output logic                        out_last,
  output logic [n-1:0]                out_data,
  input  logic                        out_ready,
  input  logic [NUM_VC-1:0]           out_vc_ready
`ifdef VC_LINK_OCCUPANCY_EN
  ,
  output logic [NUM_VC*($clog2(DEPTH)+1)-1:0] vc_occupancy,
  output logic                                vc_overflow_err
`endif
);

  localparam int VW = $clog2(NUM_VC);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [VW:0]   NUM_VC_W = (VW+1)'(NUM_VC);
  localparam logic [CW-1:0] DEPTH_W  = CW'(DEPTH);
  localparam logic [VW-1:0] LAST_VC  = VW'(NUM_VC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Round-robin search: first requester at or after start, wrapping.
  // Returns {found, index}.
  function automatic logic [VW:0] rr_pick(input logic [NUM_VC-1:0] req,
                                          input logic [VW-1:0]     start);
    logic [VW:0] res;
    int          idx;
    res = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = int'(start) + i;
      idx = (idx >= NUM_VC) ? idx - NUM_VC : idx;
      if (!res[VW] && req[idx]) begin
        res = {1'b1, VW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // FIFO storage: {last, data} per slot
  logic [n:0]    mem_q    [NUM_VC][DEPTH];
  logic [n:0]    mem_d    [NUM_VC][DEPTH];
  logic [CW-1:0] count_q  [NUM_VC];
  logic [CW-1:0] count_d  [NUM_VC];
  logic [PW-1:0] wr_ptr_q [NUM_VC];
  logic [PW-1:0] wr_ptr_d [NUM_VC];
  logic [PW-1:0] rd_ptr_q [NUM_VC];
  logic [PW-1:0] rd_ptr_d [NUM_VC];
  logic [PW-1:0] head_idx [NUM_VC];

  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] push_vec;
  logic [NUM_VC-1:0] pop_vec;
  logic [NUM_VC-1:0] avail;
  logic              in_vc_ok;
  logic              pop;

  state_t        state_q, state_d;
  logic [VW-1:0] rr_ptr_q, rr_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [VW-1:0] out_vc_q, out_vc_d;
  logic          out_last_q, out_last_d;
  logic [n-1:0]  out_data_q, out_data_d;

  logic          load;
  logic [VW-1:0] load_vc;
  logic [VW:0]   pick;
  logic [VW-1:0] next_rr;

  assign in_vc_ok = ({1'b0, in_vc} < NUM_VC_W);
  assign pop      = out_valid_q && out_ready;

  // Space is derived from registered counts only; a pop never frees space in
  // the same cycle. Reset holds every VC closed.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      full[v] = (count_q[v] == DEPTH_W);
    end
    if (rst) begin
      in_ready = ~full;
    end else begin
      in_ready = '0;
    end
  end

  // Per-VC push/pop, pointer and occupancy updates, storage writes
  always_comb begin
    mem_d = mem_q;
    for (int v = 0; v < NUM_VC; v++) begin
      push_vec[v] = in_valid && in_vc_ok && (in_vc == VW'(v)) && in_ready[v];
      pop_vec[v]  = pop && (out_vc_q == VW'(v));
      count_d[v]  = count_q[v] + CW'(push_vec[v]) - CW'(pop_vec[v]);
      wr_ptr_d[v] = wr_ptr_q[v] + PW'(push_vec[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PW'(pop_vec[v]);
      // head and eligibility as they will be once this cycle's pop retires,
      // so the arbiter can hand over without a bubble
      head_idx[v] = rd_ptr_q[v] + PW'(pop_vec[v]);
      avail[v]    = ((count_q[v] - CW'(pop_vec[v])) != '0) && out_vc_ready[v];
      if (push_vec[v]) begin
        mem_d[v][wr_ptr_q[v]] = {in_last, in_data};
      end else begin
        mem_d[v][wr_ptr_q[v]] = mem_q[v][wr_ptr_q[v]];
      end
    end
  end

  assign next_rr = (out_vc_q == LAST_VC) ? '0 : out_vc_q + VW'(1);

  // Arbiter next-state: grant, hold, lock, and loading of the output flit.
  // A tail handshake re-arbitrates in the same cycle, and a body handshake
  // with the next flit already buffered stays presenting, giving 1 flit/cycle.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    out_vc_d   = out_vc_q;
    out_last_d = out_last_q;
    out_data_d = out_data_q;
    load       = 1'b0;
    load_vc    = out_vc_q;
    pick       = '0;
    case (state_q)
      IDLE: begin
        pick = rr_pick(avail, rr_ptr_q);
        if (pick[VW]) begin
          load    = 1'b1;
          load_vc = pick[VW-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (pop && out_last_q) begin
          rr_ptr_d = next_rr;
          pick     = rr_pick(avail, next_rr);
          if (pick[VW]) begin
            load    = 1'b1;
            load_vc = pick[VW-1:0];
          end else begin
            state_d = IDLE;
          end
        end else if (pop) begin
          if (avail[out_vc_q]) begin
            load = 1'b1;
          end else begin
            state_d = LOCKED;
          end
        end else begin
          state_d = PRESENT;
        end
      end
      LOCKED: begin
        if (avail[out_vc_q]) begin
          load = 1'b1;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      state_d                  = PRESENT;
      out_vc_d                 = load_vc;
      {out_last_d, out_data_d} = mem_q[load_vc][head_idx[load_vc]];
    end else begin
      state_d = state_d;
    end
    out_valid_d = (state_d == PRESENT);
  end

  // State, FIFO and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_vc_q    <= '0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        count_q[v]  <= '0;
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[v][d] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_vc_q    <= out_vc_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      for (int v = 0; v < NUM_VC; v++) begin
        count_q[v]  <= count_d[v];
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[v][d] <= mem_d[v][d];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_vc    = out_vc_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

`ifdef VC_LINK_OCCUPANCY_EN
  logic [NUM_VC*CW-1:0] occ_d, occ_q;
  logic                 ovf_d, ovf_q;

  // Occupancy snapshot and sticky overflow detection
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      occ_d[v*CW +: CW] = count_d[v];
    end
    if (in_valid && (!in_vc_ok || !in_ready[in_vc])) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Occupancy and overflow registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
    end
  end

  assign vc_occupancy    = occ_q;
  assign vc_overflow_err = ovf_q;
`endif

endmodule

// File: tb/tb_vc_link_buffer.sv
module tb_vc_link_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_vc;
  logic        in_last;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [1:0]  out_vc;
  logic        out_last;
  logic [31:0] out_data;
  logic        out_ready;
  logic [3:0]  out_vc_ready;
`ifdef VC_LINK_OCCUPANCY_EN
  logic [11:0] vc_occupancy;
  logic        vc_overflow_err;
`endif

  int checks = 0;
  int errors = 0;

  vc_link_buffer #(.n(32), .NUM_VC(4), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .in_last      (in_last),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_vc       (out_vc),
    .out_last     (out_last),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .out_vc_ready (out_vc_ready)
`ifdef VC_LINK_OCCUPANCY_EN
    ,
    .vc_occupancy    (vc_occupancy),
    .vc_overflow_err (vc_overflow_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] vc, input logic [31:0] data,
                         input logic last);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_vc"},    64'(out_vc),    64'(vc));
    chk({tag, "_data"},  64'(out_data),  64'(data));
    chk({tag, "_last"},  64'(out_last),  64'(last));
  endtask

  task automatic push(input logic [1:0] vc, input logic [31:0] data, input logic last);
    in_valid = 1'b1;
    in_vc    = vc;
    in_data  = data;
    in_last  = last;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    out_vc_ready = 4'b0000;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_vc        = 2'd0;
    in_last      = 1'b0;
    in_data      = 32'h0;
    out_ready    = 1'b0;
    out_vc_ready = 4'b0000;
    step();
    step();
    chk("rst_in_ready",  64'(in_ready),  64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_vc",    64'(out_vc),    64'h0);
    chk("rst_out_last",  64'(out_last),  64'h0);
    chk("rst_out_data",  64'(out_data),  64'h0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready",  64'(in_ready),  64'hF);

    // Single flit on VC2: written at one edge, presented at the next
    out_ready    = 1'b1;
    out_vc_ready = 4'b1111;
    push(2'd2, 32'hA5A5_A5A5, 1'b1);
    chk("single_lat0", 64'(out_valid), 64'd0);
    step();
    chk_out("single", 2'd2, 32'hA5A5_A5A5, 1'b1);
    step();
    chk("single_drain", 64'(out_valid), 64'd0);
    chk("single_ready", 64'(in_ready),  64'hF);

    // Fill VC0, overflow attempt ignored, FIFO-order drain
    out_vc_ready = 4'b0000;
    for (int k = 0; k < 4; k++) push(2'd0, 32'h100 + 32'(k), 1'b1);
    chk("fill_ready", 64'(in_ready), 64'hE);
    push(2'd0, 32'h1FF, 1'b1);
    chk("fill_ovf_ready", 64'(in_ready), 64'hE);
    out_vc_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out("fill_pop", 2'd0, 32'h100 + 32'(k), 1'b1);
    end
    step();
    chk("fill_empty", 64'(out_valid), 64'd0);
    chk("fill_ready2", 64'(in_ready), 64'hF);

    // Round-robin across all four VCs starting from pointer 0
    do_reset();
    for (int k = 0; k < 4; k++) push(2'(k), 32'h200 + 32'(k), 1'b1);
    out_ready    = 1'b1;
    out_vc_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out("rr", 2'(k), 32'h200 + 32'(k), 1'b1);
    end
    step();
    chk("rr_idle", 64'(out_valid), 64'd0);
    // pointer wrapped to 0: VC0 wins over VC3
    out_vc_ready = 4'b0000;
    push(2'd3, 32'h213, 1'b1);
    push(2'd0, 32'h210, 1'b1);
    out_vc_ready = 4'b1111;
    step();
    chk_out("rr_wrap0", 2'd0, 32'h210, 1'b1);
    step();
    chk_out("rr_wrap3", 2'd3, 32'h213, 1'b1);
    step();
    chk("rr_wrap_idle", 64'(out_valid), 64'd0);

    // Wormhole: VC1 3-flit packet with stalled middle flit, VC2 waits
    out_vc_ready = 4'b0000;
    push(2'd1, 32'h301, 1'b0);
    push(2'd2, 32'h3F2, 1'b1);
    out_vc_ready = 4'b1111;
    step();
    chk_out("worm_h", 2'd1, 32'h301, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("worm_lock_valid", 64'(out_valid), 64'd0);
      chk("worm_lock_vc",    64'(out_vc),    64'd1);
    end
    push(2'd1, 32'h302, 1'b0);
    chk("worm_lock_push", 64'(out_valid), 64'd0);
    in_valid = 1'b1;
    in_vc    = 2'd1;
    in_data  = 32'h303;
    in_last  = 1'b1;
    step();
    in_valid = 1'b0;
    chk_out("worm_b", 2'd1, 32'h302, 1'b0);
    step();
    chk_out("worm_t", 2'd1, 32'h303, 1'b1);
    step();
    chk_out("worm_vc2", 2'd2, 32'h3F2, 1'b1);
    step();
    chk("worm_idle", 64'(out_valid), 64'd0);

    // Backpressure on VC3 with eligibility dropping mid-presentation
    out_ready = 1'b0;
    push(2'd3, 32'h4A3, 1'b1);
    step();
    chk_out("bp0", 2'd3, 32'h4A3, 1'b1);
    out_vc_ready = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out("bp_hold", 2'd3, 32'h4A3, 1'b1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_done", 64'(out_valid), 64'd0);
    chk("bp_ready", 64'(in_ready), 64'hF);

    // Reset while a packet on VC1 is mid-flight with 2 flits buffered
    out_vc_ready = 4'b0000;
    push(2'd1, 32'h501, 1'b0);
    push(2'd1, 32'h502, 1'b0);
    push(2'd1, 32'h503, 1'b0);
    out_vc_ready = 4'b1111;
    step();
    chk_out("mid_h", 2'd1, 32'h501, 1'b0);
    step();
    out_ready = 1'b0;
    chk_out("mid_b", 2'd1, 32'h502, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'h0);
    chk("mid_rst_data",  64'(out_data),  64'h0);
    chk("mid_rst_vc",    64'(out_vc),    64'h0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rel_ready", 64'(in_ready), 64'hF);
    out_ready    = 1'b1;
    out_vc_ready = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_no_stale", 64'(out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
